// File: rtl/sample_run_sequencer.sv
// ---------------------------------------------------------------------------
// sample_run_sequencer
//
// Run-level scheduler for a batch of annealing samples. For each sample it
// triggers the row accumulation controller, keeps row addressing enabled
// while the array is swept a programmed number of times, requests a stop and
// then waits for the Hamiltonian calculator to finish. It reports a
// per-sample result strobe, a batch-end pulse and sticky abort / watchdog
// flags.
//
// Ports:
//   clk               in   clock
//   reset             in   asynchronous active-high reset
//   start             in   batch start pulse, honoured only when idle
//   abort             in   terminate the running batch (level, per cycle)
//   num_samples       in   samples per batch, latched on accepted start
//   sweeps_per_sample in   array passes per sample, 0 behaves as 1
//   array_done        in   pulse at the end of the last row of a sweep
//   cal_done          in   pulse when the Hamiltonian is available
//   sample_trig       out  one-cycle sample start
//   stop              out  one-cycle stop request
//   address_enable    out  row addressing enable
//   result_valid      out  Hamiltonian for sample_idx is valid
//   sample_idx        out  0-based index of the current sample
//   busy              out  high whenever not idle
//   done              out  one-cycle batch-end pulse
//   aborted           out  sticky: last batch ended by abort or timeout
//   timeout_err       out  sticky: watchdog fired
//   state             out  debug view of the current state
//
// Every output is decoded from registered state or a registered flag, so
// there is no combinational path from any input to any output.
// ---------------------------------------------------------------------------
module sample_run_sequencer #(
   parameter int SAMPLE_W  = 16,
   parameter int SWEEP_W   = 8,
   parameter int TIMEOUT_W = 12
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic                abort,
   input  logic [SAMPLE_W-1:0] num_samples,
   input  logic [SWEEP_W-1:0]  sweeps_per_sample,
   input  logic                array_done,
   input  logic                cal_done,
   output logic                sample_trig,
   output logic                stop,
   output logic                address_enable,
   output logic                result_valid,
   output logic [SAMPLE_W-1:0] sample_idx,
   output logic                busy,
   output logic                done,
   output logic                aborted,
   output logic                timeout_err,
   output logic [2:0]          state
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_TRIG     = 3'd1,
      ST_SWEEP    = 3'd2,
      ST_STOP_REQ = 3'd3,
      ST_WAIT_CAL = 3'd4,
      ST_NEXT     = 3'd5,
      ST_ABORT    = 3'd6,
      ST_DONE     = 3'd7
   } state_t;

   localparam logic [SAMPLE_W-1:0]  SAMPLE_ONE = {{(SAMPLE_W-1){1'b0}}, 1'b1};
   localparam logic [SWEEP_W-1:0]   SWEEP_ONE  = {{(SWEEP_W-1){1'b0}}, 1'b1};
   localparam logic [TIMEOUT_W-1:0] WD_ONE     = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
   // The watchdog counter starts at 0 on state entry, so reaching limit-1
   // means the limit (2^TIMEOUT_W-1) cycles have been spent in the state.
   localparam logic [TIMEOUT_W-1:0] WD_LAST    = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

   state_t                state_q,       state_d;
   logic [SAMPLE_W-1:0]   sample_idx_q,  sample_idx_d;
   logic [SAMPLE_W-1:0]   num_samples_q, num_samples_d;
   logic [SWEEP_W-1:0]    sweeps_q,      sweeps_d;
   logic [SWEEP_W-1:0]    sweep_cnt_q,   sweep_cnt_d;
   logic [TIMEOUT_W-1:0]  wd_q,          wd_d;
   logic                  aborted_q,     aborted_d;
   logic                  timeout_q,     timeout_d;
   logic                  wd_fire_s;

   assign wd_fire_s = (wd_q == WD_LAST);

   // State and counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         sample_idx_q  <= '0;
         num_samples_q <= '0;
         sweeps_q      <= '0;
         sweep_cnt_q   <= '0;
         wd_q          <= '0;
         aborted_q     <= 1'b0;
         timeout_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         sample_idx_q  <= sample_idx_d;
         num_samples_q <= num_samples_d;
         sweeps_q      <= sweeps_d;
         sweep_cnt_q   <= sweep_cnt_d;
         wd_q          <= wd_d;
         aborted_q     <= aborted_d;
         timeout_q     <= timeout_d;
      end
   end

   // Next-state, counter and sticky-flag logic.
   always_comb begin
      state_d       = state_q;
      sample_idx_d  = sample_idx_q;
      num_samples_d = num_samples_q;
      sweeps_d      = sweeps_q;
      sweep_cnt_d   = sweep_cnt_q;
      wd_d          = '0;            // clears on every state change by default
      aborted_d     = aborted_q;
      timeout_d     = timeout_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               num_samples_d = num_samples;
               sweeps_d      = (sweeps_per_sample == '0) ? SWEEP_ONE : sweeps_per_sample;
               sample_idx_d  = '0;
               aborted_d     = 1'b0;
               timeout_d     = 1'b0;
               state_d       = (num_samples == '0) ? ST_DONE : ST_TRIG;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_TRIG: begin
            if (abort) begin
               state_d = ST_ABORT;
            end else begin
               sweep_cnt_d = '0;
               state_d     = ST_SWEEP;
            end
         end
         ST_SWEEP: begin
            if (abort) begin
               state_d = ST_ABORT;
            end else if (wd_fire_s) begin
               timeout_d = 1'b1;
               state_d   = ST_ABORT;
            end else if (array_done) begin
               // watchdog restarts on every completed sweep (wd_d default)
               if (sweep_cnt_q == (sweeps_q - SWEEP_ONE)) begin
                  state_d = ST_STOP_REQ;
               end else begin
                  sweep_cnt_d = sweep_cnt_q + SWEEP_ONE;
               end
            end else begin
               wd_d = wd_q + WD_ONE;
            end
         end
         ST_STOP_REQ: begin
            if (abort) begin
               state_d = ST_ABORT;
            end else begin
               state_d = ST_WAIT_CAL;
            end
         end
         ST_WAIT_CAL: begin
            if (abort) begin
               state_d = ST_ABORT;
            end else if (wd_fire_s) begin
               timeout_d = 1'b1;
               state_d   = ST_ABORT;
            end else if (cal_done) begin
               state_d = ST_NEXT;
            end else begin
               wd_d = wd_q + WD_ONE;
            end
         end
         ST_NEXT: begin
            if (abort) begin
               state_d = ST_ABORT;
            end else if (sample_idx_q == (num_samples_q - SAMPLE_ONE)) begin
               state_d = ST_DONE;
            end else begin
               sample_idx_d = sample_idx_q + SAMPLE_ONE;
               state_d      = ST_TRIG;
            end
         end
         ST_ABORT: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Any way into ABORT (request or watchdog) marks the batch as aborted.
      if ((state_d == ST_ABORT) && (state_q != ST_ABORT)) begin
         aborted_d = 1'b1;
      end else begin
         aborted_d = aborted_d;
      end
   end

   assign sample_trig    = (state_q == ST_TRIG);
   assign stop           = (state_q == ST_STOP_REQ) || (state_q == ST_ABORT);
   assign address_enable = (state_q == ST_TRIG)     || (state_q == ST_SWEEP) ||
                           (state_q == ST_STOP_REQ) || (state_q == ST_WAIT_CAL) ||
                           (state_q == ST_NEXT);
   // NEXT is only reachable from WAIT_CAL on cal_done, so it marks a result.
   assign result_valid   = (state_q == ST_NEXT);
   assign sample_idx     = sample_idx_q;
   assign busy           = (state_q != ST_IDLE);
   assign done           = (state_q == ST_DONE);
   assign aborted        = aborted_q;
   assign timeout_err    = timeout_q;
   assign state          = state_q;

endmodule

// File: tb/tb_sample_run_sequencer.sv
// Self-checking bench for sample_run_sequencer (TIMEOUT_W = 4, limit 15).
module tb_sample_run_sequencer;

   localparam int LIM = 15;
   localparam int P_IDLE = 0, P_TRIG = 1, P_SWEEP = 2, P_STOPQ = 3,
                  P_WAIT = 4, P_NEXT = 5, P_ABORT = 6, P_DONE = 7;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] num_samples = 16'd0;
   logic [7:0]  sps = 8'd0;
   logic        array_done = 1'b0;
   logic        cal_done = 1'b0;
   logic        sample_trig, stop, address_enable, result_valid;
   logic [15:0] sample_idx;
   logic        busy, done, aborted, timeout_err;
   logic [2:0]  state;

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   sample_run_sequencer #(.SAMPLE_W(16), .SWEEP_W(8), .TIMEOUT_W(4)) dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .num_samples(num_samples), .sweeps_per_sample(sps),
      .array_done(array_done), .cal_done(cal_done),
      .sample_trig(sample_trig), .stop(stop), .address_enable(address_enable),
      .result_valid(result_valid), .sample_idx(sample_idx), .busy(busy),
      .done(done), .aborted(aborted), .timeout_err(timeout_err), .state(state)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model: phase + remaining budgets ----------
   int m_ph, m_idx, m_n, m_sw, m_left, m_budget;
   bit m_ab, m_to;

   always @(posedge clk or posedge reset) begin : model
      int ph, idx, n, sw, left, budget;
      bit ab, to;
      if (reset) begin
         m_ph <= P_IDLE; m_idx <= 0; m_n <= 0; m_sw <= 1;
         m_left <= 0; m_budget <= 0; m_ab <= 1'b0; m_to <= 1'b0;
      end else begin
         ph = m_ph; idx = m_idx; n = m_n; sw = m_sw;
         left = m_left; budget = m_budget; ab = m_ab; to = m_to;
         if (abort && ph >= P_TRIG && ph <= P_NEXT) begin
            ph = P_ABORT; ab = 1'b1;
         end else begin
            case (ph)
               P_IDLE: if (start) begin
                  ab = 1'b0; to = 1'b0; idx = 0;
                  n = int'(num_samples);
                  sw = (sps == 8'd0) ? 1 : int'(sps);
                  ph = (n == 0) ? P_DONE : P_TRIG;
               end
               P_TRIG: begin left = sw; budget = LIM; ph = P_SWEEP; end
               P_SWEEP: begin
                  budget = budget - 1;
                  if (budget == 0) begin to = 1'b1; ab = 1'b1; ph = P_ABORT; end
                  else if (array_done) begin
                     budget = LIM; left = left - 1;
                     if (left == 0) ph = P_STOPQ;
                  end
               end
               P_STOPQ: begin budget = LIM; ph = P_WAIT; end
               P_WAIT: begin
                  budget = budget - 1;
                  if (budget == 0) begin to = 1'b1; ab = 1'b1; ph = P_ABORT; end
                  else if (cal_done) ph = P_NEXT;
               end
               P_NEXT: if (idx == n - 1) ph = P_DONE;
                       else begin idx = idx + 1; ph = P_TRIG; end
               P_ABORT: ph = P_DONE;
               P_DONE:  ph = P_IDLE;
               default: ph = P_IDLE;
            endcase
         end
         m_ph <= ph; m_idx <= idx; m_n <= n; m_sw <= sw;
         m_left <= left; m_budget <= budget; m_ab <= ab; m_to <= to;
      end
   end

   // ---------------- per-cycle compare + pulse monitor ----------------------
   int n_trig, n_stop, n_rv, n_done;
   int rv_idx[$];

   always @(negedge clk) begin : compare
      logic [26:0] exp_v, act_v;
      if (chk_en) begin
         exp_v = {3'(m_ph), 16'(m_idx), m_ph == P_TRIG,
                  (m_ph == P_STOPQ) || (m_ph == P_ABORT),
                  (m_ph >= P_TRIG) && (m_ph <= P_NEXT),
                  m_ph == P_NEXT, m_ph != P_IDLE, m_ph == P_DONE, m_ab, m_to};
         act_v = {state, sample_idx, sample_trig, stop, address_enable,
                  result_valid, busy, done, aborted, timeout_err};
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle_compare t=%0t: dut={st,idx,trig,stop,ae,rv,busy,done,ab,to}=%h model=%h",
                     $time, act_v, exp_v);
         end
         if (sample_trig === 1'b1) n_trig++;
         if (stop === 1'b1) n_stop++;
         if (done === 1'b1) n_done++;
         if (result_valid === 1'b1) begin n_rv++; rv_idx.push_back(int'(sample_idx)); end
      end
   end

   // ---------------- stimulus helpers ---------------------------------------
   bit resp_en = 1'b0;
   bit cal_en  = 1'b0;
   int ad_cnt  = 0;
   int cal_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   // Advance to just after the next falling edge; clear pulses, run responder.
   task automatic tick();
      @(negedge clk); #1;
      start = 1'b0; abort = 1'b0; array_done = 1'b0; cal_done = 1'b0;
      if (resp_en) begin
         ad_cnt++;
         if (ad_cnt >= 10) begin ad_cnt = 0; array_done = 1'b1; end
         if (cal_en) begin
            if (stop) cal_cnt = 10;
            else if (cal_cnt > 0) begin
               cal_cnt--;
               if (cal_cnt == 0) cal_done = 1'b1;
            end
         end
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int budget, input string name);
      int n = 0;
      while (state !== s && n < budget) begin tick(); n++; end
      checks++;
      if (state !== s) begin
         errors++;
         $display("FAIL %s: state=%0d after %0d cycles, required %0d", name, state, n, s);
      end
   endtask

   task automatic go(input int n, input int s);
      start = 1'b1; num_samples = n[15:0]; sps = s[7:0];
      tick();
   endtask

   task automatic clr_counts();
      n_trig = 0; n_stop = 0; n_rv = 0; n_done = 0; rv_idx.delete();
   endtask

   initial begin
      int cyc;
      #1 reset = 1'b1;
      chk_en = 1'b1;
      #1;
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_outs", {23'd0, sample_trig, stop, address_enable, result_valid,
                         busy, done, aborted, timeout_err}, 32'd0);
      chk("reset_idx", 32'(sample_idx), 32'd0);
      tick(); tick();
      reset = 1'b0;
      tick();

      // 1: basic batch, 3 samples x 2 sweeps
      resp_en = 1'b1; cal_en = 1'b1; clr_counts();
      go(3, 2);
      chk("t1_trig_latency", {30'd0, sample_trig, address_enable}, 32'h3);
      wait_state(3'd0, 400, "t1_finish");
      chk("t1_trigs", n_trig, 3);
      chk("t1_stops", n_stop, 3);
      chk("t1_results", n_rv, 3);
      chk("t1_dones", n_done, 1);
      chk("t1_idx_order", (rv_idx.size() == 3) ? {rv_idx[0][7:0], rv_idx[1][7:0], rv_idx[2][7:0]} : 24'hFFFFFF,
          32'h000102);
      chk("t1_flags", {aborted, timeout_err}, 32'd0);

      // 2: zero sweeps behaves as one
      resp_en = 1'b0; cal_en = 1'b0; clr_counts();
      go(1, 0);
      tick();                                   // now in SWEEP
      array_done = 1'b1;
      tick();
      chk("t2_stop_after_first_ad", {29'd0, state, stop} , {29'd0, 3'd3, 1'b1});
      tick();                                   // WAIT_CAL
      cal_done = 1'b1;
      tick();
      chk("t2_result", {15'd0, result_valid, sample_idx}, {15'd0, 1'b1, 16'd0});
      tick();
      chk("t2_done_after_rv", 32'(done), 32'd1);
      tick();

      // 3: zero samples
      clr_counts();
      go(0, 1);
      chk("t3_done_k1", {28'd0, done, busy, sample_trig, address_enable}, 32'hC);
      tick();
      chk("t3_busy_one_cycle", 32'(busy), 32'd0);
      chk("t3_no_trig", n_trig, 0);

      // 4: abort during second sample's sweep
      resp_en = 1'b1; cal_en = 1'b1; clr_counts();
      go(3, 2);
      wait_state(3'd5, 300, "t4_first_result");
      wait_state(3'd2, 20, "t4_second_sweep");
      tick(); tick(); tick();
      chk("t4_in_sweep_idx1", {13'd0, state, sample_idx}, {13'd0, 3'd2, 16'd1});
      abort = 1'b1;
      tick();
      chk("t4_abort_k1", {27'd0, state, stop, address_enable}, {27'd0, 3'd6, 1'b1, 1'b0});
      chk("t4_aborted", 32'(aborted), 32'd1);
      tick();
      chk("t4_done_k2", 32'(done), 32'd1);
      tick();
      chk("t4_aborted_sticky", 32'(aborted), 32'd1);
      go(1, 1);
      chk("t4_start_clears", {30'd0, aborted, sample_trig}, 32'd1);
      abort = 1'b1;
      tick();
      wait_state(3'd0, 10, "t4_abort_end");

      // 5: watchdog in WAIT_CAL
      cal_en = 1'b0; clr_counts();
      go(1, 1);
      wait_state(3'd4, 100, "t5_reach_wait");
      cyc = 0;
      while (state === 3'd4 && cyc < 100) begin cyc++; tick(); end
      chk("t5_wait_cycles", cyc, LIM);
      chk("t5_abort_flags", {28'd0, state, timeout_err}, {28'd0, 3'd6, 1'b1});
      tick();
      chk("t5_done", 32'(done), 32'd1);
      chk("t5_no_result", n_rv, 0);
      tick();

      // 6: ignored inputs, then reset mid-WAIT_CAL
      cal_en = 1'b1; clr_counts();
      go(2, 1);
      wait_state(3'd2, 20, "t6_sweep");
      array_done = 1'b0; cal_done = 1'b1; start = 1'b1; num_samples = 16'd7;
      tick();
      chk("t6_ignored", {12'd0, state, busy, sample_idx}, {12'd0, 3'd2, 1'b1, 16'd0});
      chk("t6_no_rv", n_rv, 0);
      wait_state(3'd4, 40, "t6_wait_cal");
      tick(); tick();
      reset = 1'b1;
      #1;
      chk("t6_reset_now", {20'd0, state, sample_trig, stop, address_enable, result_valid,
                           busy, done, aborted, timeout_err}, 32'd0);
      chk("t6_reset_idx", 32'(sample_idx), 32'd0);
      tick();
      reset = 1'b0;
      resp_en = 1'b0; cal_en = 1'b0;
      tick();

      // randomized traffic, every cycle checked against the model
      for (int i = 0; i < 4000; i++) begin
         if (reset) reset = 1'b0;
         tick();
         start       = ($urandom_range(0, 99) < 10);
         num_samples = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom_range(1, 4));
         sps         = 8'($urandom_range(0, 3));
         abort       = ($urandom_range(0, 199) == 0);
         array_done  = ($urandom_range(0, 99) < 15);
         cal_done    = ($urandom_range(0, 99) < 12);
         if ($urandom_range(0, 599) == 0) reset = 1'b1;
      end
      reset = 1'b0;
      tick(); tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
